switch_debounce_bank: RTL
=========================

// Module: switch_debounce_bank
// PURPOSE
//   Front-end conditioning for raw board push-button/switch inputs feeding the LED demux
//   select lines and other control logic. Per channel: 2-flop synchronizer, then a
//   debounce counter FSM. Output is a clean, glitch-free level per switch.
//   Optionally also produces single-cycle rise/fall pulses.
//   Sits between the board pins (i_Switch_*) and the demux select inputs (i_Sel0/i_Sel1).
// PARAMETERS
//   NUM_SW          2        number of independent switch channels (>=1)
//   DEBOUNCE_LIMIT  250000   stable cycles required before level update (10 ms @ 25 MHz; >=1)
//   CNT_W           $clog2(DEBOUNCE_LIMIT+1)  counter width (derived localparam)
// PORTS
//   i_Clk      in   1        system clock; all logic on posedge
//   i_Rst_L    in   1        asynchronous, active-low reset
//   i_Switch   in   NUM_SW   raw asynchronous switch inputs, bit n = channel n
//   o_Switch   out  NUM_SW   debounced level per channel
//   o_Rise     out  NUM_SW   1-cycle pulse on debounced 0->1 (DEBOUNCE_EDGE_EN only)
//   o_Fall     out  NUM_SW   1-cycle pulse on debounced 1->0 (DEBOUNCE_EDGE_EN only)
// BEHAVIOUR
//   Reset (i_Rst_L=0, async assert, sync release via normal clocking): sync flops=0,
//     counters=0, FSM=S_STABLE, o_Switch=0, o_Rise=0, o_Fall=0.
//   Sync: r_Sync1 <= i_Switch[n]; r_Sync2 <= r_Sync1. Only r_Sync2 is used downstream.
//   Per-channel FSM, 2 states:
//     S_STABLE : cnt=0. If r_Sync2 != o_Switch[n] -> S_PENDING, cnt<=1.
//     S_PENDING: if r_Sync2 == o_Switch[n] -> S_STABLE, cnt<=0 (glitch rejected).
//                elif cnt == DEBOUNCE_LIMIT -> o_Switch[n]<=r_Sync2, cnt<=0, -> S_STABLE.
//                else cnt<=cnt+1.
//     With DEBOUNCE_LIMIT=1, a mismatch updates o_Switch on the edge after the one that
//     entered S_PENDING.
//   Latency: the input changes before edge k and is captured in r_Sync1 at edge k, in
//     r_Sync2 at edge k+1. S_PENDING is entered at edge k+2; o_Switch updates at edge
//     k+2+DEBOUNCE_LIMIT.
//   Any pulse or bounce holding r_Sync2 at the new value for fewer than DEBOUNCE_LIMIT+1
//     consecutive cycles produces no output change.
//   Counter saturates logically at DEBOUNCE_LIMIT (never wraps). CNT_W is sized so
//     DEBOUNCE_LIMIT fits.
//   Channels fully independent; simultaneous changes on several channels are each timed
//     separately.
//   Reset mid-count: pending transition discarded; o_Switch returns to 0 immediately.
//   No combinational path from i_Switch to any output.
// CONFIGURATION
//   Macro DEBOUNCE_EDGE_EN:
//     defined  : o_Rise/o_Fall ports exist. Each is registered and asserts for exactly one
//                cycle, on the same edge o_Switch[n] changes (rise if new=1, fall if new=0).
//                Both are 0 otherwise.
//     undefined: o_Rise/o_Fall ports and their logic are omitted entirely; o_Switch
//                behaviour is unchanged.
// STRUCTURE
//   Package debounce_pkg: state encoding constants S_STABLE=1'b0, S_PENDING=1'b1.
//     Default DEBOUNCE_LIMIT constant for 25 MHz/10 ms.
//   Sub-module debounce_channel (sync + FSM + counter + optional edge regs for one bit).
//     Top instantiates NUM_SW copies via generate loop.
// TESTING  (bench uses DEBOUNCE_LIMIT=4, NUM_SW=2, DEBOUNCE_EDGE_EN defined)
//   1 Reset: hold i_Rst_L=0, i_Switch=2'b11 -> o_Switch=00, o_Rise=o_Fall=00. Release:
//     o_Switch[0] rises exactly 6 edges after the first edge post-release.
//   2 Clean press ch0: i_Switch 00->01, held -> o_Switch=01 at edge k+6; o_Rise=01 for that
//     single cycle only.
//   3 Bounce ch1: toggle i_Switch[1] with high runs of 3 cycles and low runs of 2 cycles,
//     8 times -> o_Switch[1] stays 0, no pulses. Then hold 1 -> rises 6 edges after the
//     final rising edge.
//   4 Simultaneous: i_Switch 00->11 on the same cycle -> both bits rise on the same edge,
//     o_Rise=11 for 1 cycle. Then 11->00 -> o_Fall=11 for 1 cycle.
//   5 Reset mid-operation: assert i_Rst_L=0 two cycles into S_PENDING -> no rise occurs.
//     After release and input still held, a full 6-edge delay is observed again.
//   6 Macro off: recompile without DEBOUNCE_EDGE_EN -> rerun tests 2 and 3.
//     o_Switch timing is identical.

Source files
------------

// File: rtl/debounce_pkg.sv
// rtl/debounce_pkg.sv - shared state encoding and default timing for the switch debouncer
`timescale 1ns/1ps
package debounce_pkg;

    typedef enum logic {
        S_STABLE  = 1'b0,
        S_PENDING = 1'b1
    } state_t;

    // 10 ms of stability at a 25 MHz system clock
    localparam int DEBOUNCE_LIMIT_DEFAULT = 250000;

endpackage

// File: rtl/debounce_channel.sv
// rtl/debounce_channel.sv - one switch channel: 2-flop synchronizer, debounce FSM, edge pulses (DEBOUNCE_EDGE_EN)
`timescale 1ns/1ps
module debounce_channel
    import debounce_pkg::*;
#(
    parameter int DEBOUNCE_LIMIT = DEBOUNCE_LIMIT_DEFAULT,
    parameter int CNT_W          = $clog2(DEBOUNCE_LIMIT + 1)
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
`ifdef DEBOUNCE_EDGE_EN
    output logic rise,
    output logic fall,
`endif
    output logic level
);

    localparam logic [CNT_W-1:0] LIMIT_C = CNT_W'(DEBOUNCE_LIMIT);
    localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);

    logic             sync1;
    logic             sync2;
    state_t           state;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            state <= S_STABLE;
            cnt   <= '0;
            level <= 1'b0;
`ifdef DEBOUNCE_EDGE_EN
            rise  <= 1'b0;
            fall  <= 1'b0;
`endif
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
`ifdef DEBOUNCE_EDGE_EN
            rise  <= 1'b0;
            fall  <= 1'b0;
`endif
            case (state)
                S_STABLE: begin
                    cnt <= '0;
                    if (sync2 != level) begin
                        state <= S_PENDING;
                        cnt   <= ONE_C;
                    end
                end
                S_PENDING: begin
                    // Any return to the current level restarts the stability window
                    if (sync2 == level) begin
                        state <= S_STABLE;
                        cnt   <= '0;
                    end else if (cnt == LIMIT_C) begin
                        level <= sync2;
                        state <= S_STABLE;
                        cnt   <= '0;
`ifdef DEBOUNCE_EDGE_EN
                        rise  <= sync2;
                        fall  <= ~sync2;
`endif
                    end else begin
                        cnt <= cnt + ONE_C;
                    end
                end
                default: begin
                    state <= S_STABLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: rtl/switch_debounce_bank.sv
// rtl/switch_debounce_bank.sv - bank of independent switch debouncers; edge pulse outputs under DEBOUNCE_EDGE_EN
`timescale 1ns/1ps
module switch_debounce_bank
    import debounce_pkg::*;
#(
    parameter int NUM_SW         = 2,
    parameter int DEBOUNCE_LIMIT = DEBOUNCE_LIMIT_DEFAULT
) (
    input  logic              i_Clk,
    input  logic              i_Rst_L,
    input  logic [NUM_SW-1:0] i_Switch,
`ifdef DEBOUNCE_EDGE_EN
    output logic [NUM_SW-1:0] o_Rise,
    output logic [NUM_SW-1:0] o_Fall,
`endif
    output logic [NUM_SW-1:0] o_Switch
);

    localparam int CNT_W = $clog2(DEBOUNCE_LIMIT + 1);

    for (genvar g = 0; g < NUM_SW; g++) begin : g_chan
        debounce_channel #(
            .DEBOUNCE_LIMIT(DEBOUNCE_LIMIT),
            .CNT_W         (CNT_W)
        ) u_chan (
            .clk  (i_Clk),
            .rst_n(i_Rst_L),
            .raw  (i_Switch[g]),
`ifdef DEBOUNCE_EDGE_EN
            .rise (o_Rise[g]),
            .fall (o_Fall[g]),
`endif
            .level(o_Switch[g])
        );
    end

endmodule
